// File: rtl/e_operand_stage.sv
// ---------------------------------------------------------------------------
// e_operand_stage
//
// Execute-entry operand unit for the pipelined MIPS core.
//   * Resolves rs/rt operand forwarding from the M and W stages (M wins).
//   * Selects the ALU B operand from forwarded rt data, the immediate,
//     the rt field, the shamt field, or the constant 16.
//   * Registers the results in the D/E pipeline register with stall and
//     flush control. All outputs are registered: there is no combinational
//     path from any input to any output.
//
// Ports
//   clk, reset_n        : rising-edge clock, asynchronous active-low reset
//   stall, flush        : hold / bubble control (flush overrides stall)
//   d_valid             : incoming instruction valid
//   d_rs, d_rt          : source register numbers
//   d_rd1, d_rd2        : GRF read data for rs / rt
//   d_imm32, d_shamt    : extended immediate and shift-amount field
//   d_alusrc            : B-operand source select code
//   m_fwd_en/addr/data  : M-stage forwarding source
//   w_fwd_en/addr/data  : W-stage forwarding source
//   e_valid             : registered valid
//   e_alua, e_alub      : registered ALU operands
//   e_rtdata            : registered forwarded rt value (store data)
//   e_rs, e_rt          : registered register numbers
// ---------------------------------------------------------------------------
module e_operand_stage #(
    parameter int WIDTH   = 32,
    parameter int REG_AW  = 5,
    parameter int SHAMT_W = 5,
    parameter int SRC_W   = 3
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               stall,
    input  logic               flush,
    input  logic               d_valid,
    input  logic [REG_AW-1:0]  d_rs,
    input  logic [REG_AW-1:0]  d_rt,
    input  logic [WIDTH-1:0]   d_rd1,
    input  logic [WIDTH-1:0]   d_rd2,
    input  logic [WIDTH-1:0]   d_imm32,
    input  logic [SHAMT_W-1:0] d_shamt,
    input  logic [SRC_W-1:0]   d_alusrc,
    input  logic               m_fwd_en,
    input  logic [REG_AW-1:0]  m_fwd_addr,
    input  logic [WIDTH-1:0]   m_fwd_data,
    input  logic               w_fwd_en,
    input  logic [REG_AW-1:0]  w_fwd_addr,
    input  logic [WIDTH-1:0]   w_fwd_data,
    output logic               e_valid,
    output logic [WIDTH-1:0]   e_alua,
    output logic [WIDTH-1:0]   e_alub,
    output logic [WIDTH-1:0]   e_rtdata,
    output logic [REG_AW-1:0]  e_rs,
    output logic [REG_AW-1:0]  e_rt
);

    // Operand 0 is rs (-> A), operand 1 is rt (-> B / store data).
    logic [REG_AW-1:0] w_src [2];
    logic [WIDTH-1:0]  w_grf [2];
    logic [WIDTH-1:0]  w_fwd [2];

    assign w_src[0] = d_rs;
    assign w_src[1] = d_rt;
    assign w_grf[0] = d_rd1;
    assign w_grf[1] = d_rd2;

    // Identical forwarding mux for each operand. Register 0 is hard-wired
    // in the GRF, so a producer targeting it must never be forwarded.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            logic w_m_hit;
            logic w_w_hit;

            assign w_m_hit = m_fwd_en && (m_fwd_addr == w_src[gi]) && (w_src[gi] != '0);
            assign w_w_hit = w_fwd_en && (w_fwd_addr == w_src[gi]) && (w_src[gi] != '0);

            // M is the younger producer, so it takes priority over W.
            assign w_fwd[gi] = w_m_hit ? m_fwd_data :
                               w_w_hit ? w_fwd_data :
                                         w_grf[gi];
        end
    endgenerate

    // Sized casts zero-extend, or truncate when WIDTH is narrower than the field.
    logic [WIDTH-1:0] w_rt_ext;
    logic [WIDTH-1:0] w_shamt_ext;
    logic [WIDTH-1:0] w_const16;
    logic [WIDTH-1:0] w_alub;

    assign w_rt_ext    = WIDTH'(d_rt);
    assign w_shamt_ext = WIDTH'(d_shamt);
    assign w_const16   = WIDTH'(16);

    always_comb begin
        w_alub = '0;
        case (d_alusrc)
            SRC_W'(0): w_alub = w_fwd[1];
            SRC_W'(1): w_alub = d_imm32;
            SRC_W'(2): w_alub = w_rt_ext;
            SRC_W'(3): w_alub = w_shamt_ext;
            SRC_W'(4): w_alub = w_const16;   // lui implemented as a shift by 16
            default:   w_alub = '0;
        endcase
    end

    // D/E pipeline register.
    logic              r_valid;
    logic [WIDTH-1:0]  r_alua;
    logic [WIDTH-1:0]  r_alub;
    logic [WIDTH-1:0]  r_rtdata;
    logic [REG_AW-1:0] r_rs;
    logic [REG_AW-1:0] r_rt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid  <= 1'b0;
            r_alua   <= '0;
            r_alub   <= '0;
            r_rtdata <= '0;
            r_rs     <= '0;
            r_rt     <= '0;
        end else if (flush) begin
            // A bubble is fully zeroed so downstream hazard logic sees rs=rt=0.
            r_valid  <= 1'b0;
            r_alua   <= '0;
            r_alub   <= '0;
            r_rtdata <= '0;
            r_rs     <= '0;
            r_rt     <= '0;
        end else if (!stall) begin
            r_valid  <= d_valid;
            r_alua   <= w_fwd[0];
            r_alub   <= w_alub;
            r_rtdata <= w_fwd[1];
            r_rs     <= d_rs;
            r_rt     <= d_rt;
        end
    end

    assign e_valid  = r_valid;
    assign e_alua   = r_alua;
    assign e_alub   = r_alub;
    assign e_rtdata = r_rtdata;
    assign e_rs     = r_rs;
    assign e_rt     = r_rt;

endmodule

// File: tb/tb_e_operand_stage.sv
// ---------------------------------------------------------------------------
// tb_e_operand_stage
//
// Self-checking bench for e_operand_stage. Directed cases cover reset,
// source selection, forwarding priority, register 0, stall and flush; a
// randomized phase checks every cycle against a behavioural model.
// Inputs are driven on the falling edge; outputs are sampled 1 time unit
// after the rising edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_e_operand_stage;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        stall, flush, d_valid;
    logic [4:0]  d_rs, d_rt, d_shamt;
    logic [31:0] d_rd1, d_rd2, d_imm32;
    logic [2:0]  d_alusrc;
    logic        m_fwd_en, w_fwd_en;
    logic [4:0]  m_fwd_addr, w_fwd_addr;
    logic [31:0] m_fwd_data, w_fwd_data;
    logic        e_valid;
    logic [31:0] e_alua, e_alub, e_rtdata;
    logic [4:0]  e_rs, e_rt;

    int n_checks = 0;
    int n_fail   = 0;
    int n_txn    = 0;

    // Expected register contents.
    logic        x_valid;
    logic [31:0] x_alua, x_alub, x_rtdata;
    logic [4:0]  x_rs, x_rt;

    always #5 clk = ~clk;

    e_operand_stage dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .stall      (stall),
        .flush      (flush),
        .d_valid    (d_valid),
        .d_rs       (d_rs),
        .d_rt       (d_rt),
        .d_rd1      (d_rd1),
        .d_rd2      (d_rd2),
        .d_imm32    (d_imm32),
        .d_shamt    (d_shamt),
        .d_alusrc   (d_alusrc),
        .m_fwd_en   (m_fwd_en),
        .m_fwd_addr (m_fwd_addr),
        .m_fwd_data (m_fwd_data),
        .w_fwd_en   (w_fwd_en),
        .w_fwd_addr (w_fwd_addr),
        .w_fwd_data (w_fwd_data),
        .e_valid    (e_valid),
        .e_alua     (e_alua),
        .e_alub     (e_alub),
        .e_rtdata   (e_rtdata),
        .e_rs       (e_rs),
        .e_rt       (e_rt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp_v);
        end
    endtask

    // Value an operand should read after forwarding from the M/W producers.
    function automatic logic [31:0] ref_operand(input logic [4:0] r, input logic [31:0] grf);
        if (r == 0)                            return grf;
        if (m_fwd_en && m_fwd_addr == r)       return m_fwd_data;
        if (w_fwd_en && w_fwd_addr == r)       return w_fwd_data;
        return grf;
    endfunction

    function automatic logic [31:0] ref_alub(input logic [31:0] fb);
        case (d_alusrc)
            3'd0:    return fb;
            3'd1:    return d_imm32;
            3'd2:    return {27'd0, d_rt};
            3'd3:    return {27'd0, d_shamt};
            3'd4:    return 32'd16;
            default: return 32'd0;
        endcase
    endfunction

    task automatic check_all(input string tag);
        check({tag, ".valid"},  {31'd0, e_valid}, {31'd0, x_valid});
        check({tag, ".alua"},   e_alua,           x_alua);
        check({tag, ".alub"},   e_alub,           x_alub);
        check({tag, ".rtdata"}, e_rtdata,         x_rtdata);
        check({tag, ".rs"},     {27'd0, e_rs},    {27'd0, x_rs});
        check({tag, ".rt"},     {27'd0, e_rt},    {27'd0, x_rt});
    endtask

    task automatic model_clear();
        x_valid = 1'b0; x_alua = '0; x_alub = '0; x_rtdata = '0; x_rs = '0; x_rt = '0;
    endtask

    // One clock: predict from the inputs held now, clock, then compare.
    task automatic tick(input string tag);
        logic        n_valid;
        logic [31:0] n_alua, n_alub, n_rtdata, fb;
        logic [4:0]  n_rs, n_rt;
        fb       = ref_operand(d_rt, d_rd2);
        n_valid  = d_valid;
        n_alua   = ref_operand(d_rs, d_rd1);
        n_alub   = ref_alub(fb);
        n_rtdata = fb;
        n_rs     = d_rs;
        n_rt     = d_rt;
        @(posedge clk);
        #1;
        if (flush) model_clear();
        else if (!stall) begin
            x_valid = n_valid; x_alua = n_alua; x_alub = n_alub;
            x_rtdata = n_rtdata; x_rs = n_rs; x_rt = n_rt;
        end
        n_txn++;
        $display("txn %0d %s stall=%0b flush=%0b src=%0d -> v=%0b a=%08h b=%08h rt=%08h",
                 n_txn, tag, stall, flush, d_alusrc, e_valid, e_alua, e_alub, e_rtdata);
        check_all(tag);
    endtask

    task automatic drive_idle();
        stall = 0; flush = 0; d_valid = 1; d_rs = 0; d_rt = 0;
        d_rd1 = 0; d_rd2 = 0; d_imm32 = 0; d_shamt = 0; d_alusrc = 0;
        m_fwd_en = 0; m_fwd_addr = 0; m_fwd_data = 0;
        w_fwd_en = 0; w_fwd_addr = 0; w_fwd_data = 0;
    endtask

    initial begin
        logic [31:0] sel_exp [5];
        logic [2:0]  sel_code [5];
        sel_code = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd6};
        sel_exp  = '{32'hFFFF8000, 32'h9, 32'h1F, 32'h10, 32'h0};

        drive_idle();
        reset_n = 1'b0;
        model_clear();
        #2;
        check_all("por");
        @(negedge clk);
        reset_n = 1'b1;

        // Make outputs nonzero, then assert reset mid-cycle.
        d_rs = 3; d_rt = 4; d_rd1 = 32'h1234; d_rd2 = 32'h5678;
        tick("preload");
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        model_clear();
        #1;
        check_all("async_reset");
        @(negedge clk);
        reset_n = 1'b1;
        d_rs = 1; d_rt = 2; d_rd1 = 32'h11; d_rd2 = 32'h22; d_alusrc = 0;
        tick("first_capture");
        check("first.alua", e_alua, 32'h11);
        check("first.alub", e_alub, 32'h22);

        // B-source selection.
        d_imm32 = 32'hFFFF8000; d_rt = 5'd9; d_shamt = 5'd31;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            d_alusrc = sel_code[i];
            tick("srcsel");
            check("srcsel.const", e_alub, sel_exp[i]);
        end

        // Forwarding priority.
        @(negedge clk);
        d_rs = 8; d_rt = 8; d_alusrc = 0; d_rd1 = 32'h1; d_rd2 = 32'h2;
        m_fwd_en = 1; m_fwd_addr = 8; m_fwd_data = 32'hAAAA;
        w_fwd_en = 1; w_fwd_addr = 8; w_fwd_data = 32'hBBBB;
        tick("fwd_m");
        check("fwd_m.alua", e_alua, 32'hAAAA);
        check("fwd_m.alub", e_alub, 32'hAAAA);
        check("fwd_m.rtd",  e_rtdata, 32'hAAAA);
        @(negedge clk);
        m_fwd_en = 0;
        tick("fwd_w");
        check("fwd_w.alua", e_alua, 32'hBBBB);
        check("fwd_w.alub", e_alub, 32'hBBBB);
        check("fwd_w.rtd",  e_rtdata, 32'hBBBB);

        // Register 0 never forwards.
        @(negedge clk);
        d_rs = 0; d_rd1 = 0; d_rt = 0; d_rd2 = 0;
        m_fwd_en = 1; m_fwd_addr = 0; m_fwd_data = 32'hDEAD;
        w_fwd_en = 1; w_fwd_addr = 0; w_fwd_data = 32'hDEAD;
        tick("reg0");
        check("reg0.alua", e_alua, 32'h0);

        // Stall holds, flush overrides stall.
        @(negedge clk);
        m_fwd_en = 0; w_fwd_en = 0;
        d_rs = 5; d_rd1 = 32'h5;
        tick("pre_stall");
        check("pre_stall.alua", e_alua, 32'h5);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            stall = 1; d_rd1 = $urandom; d_rs = 5'($urandom);
            m_fwd_en = 1; m_fwd_addr = 5; m_fwd_data = $urandom;
            tick("stall");
            check("stall.alua", e_alua, 32'h5);
        end
        @(negedge clk);
        flush = 1;
        tick("stall_flush");
        check("flush.valid", {31'd0, e_valid}, 32'd0);
        check("flush.alua",  e_alua, 32'd0);
        @(negedge clk);
        stall = 0; flush = 0; m_fwd_en = 0; d_rs = 6; d_rd1 = 32'h66;
        tick("release");
        check("release.alua", e_alua, 32'h66);

        // Randomized phase; small register range makes forwarding hits common.
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            stall      = ($urandom_range(0, 7) == 0);
            flush      = ($urandom_range(0, 11) == 0);
            d_valid    = 1'($urandom);
            d_rs       = 5'($urandom_range(0, 3));
            d_rt       = 5'($urandom_range(0, 3));
            d_rd1      = $urandom;
            d_rd2      = $urandom;
            d_imm32    = $urandom;
            d_shamt    = 5'($urandom);
            d_alusrc   = 3'($urandom);
            m_fwd_en   = 1'($urandom);
            m_fwd_addr = 5'($urandom_range(0, 3));
            m_fwd_data = $urandom;
            w_fwd_en   = 1'($urandom);
            w_fwd_addr = 5'($urandom_range(0, 3));
            w_fwd_data = $urandom;
            tick("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/e_operand_stage.md
Name: e_operand_stage

Overview:
- Execute-entry operand unit for the pipelined MIPS core.
- Resolves rs/rt forwarding from the M and W stages and selects the ALU B operand from register data, immediate, rt-field or shamt-field.
- Captures the results into the D/E pipeline register with stall and flush control, so the ALU sees registered, hazard-resolved operands one cycle later.
- Generalises the E-stage B-operand selection in width and source count, and adds forwarding and pipelining.

Parameters:
- WIDTH, 32, datapath width in bits.
- REG_AW, 5, register-address width; also the width of the rt field.
- SHAMT_W, 5, shift-amount field width.
- SRC_W, 3, width of the B-source select code.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- stall  in  1  hold the pipeline register.
- flush  in  1  load a bubble into the pipeline register.
- d_valid  in  1  incoming instruction is valid.
- d_rs  in  REG_AW  rs register number.
- d_rt  in  REG_AW  rt register number.
- d_rd1  in  WIDTH  GRF read data for rs.
- d_rd2  in  WIDTH  GRF read data for rt.
- d_imm32  in  WIDTH  extended immediate.
- d_shamt  in  SHAMT_W  shamt field.
- d_alusrc  in  SRC_W  B-source select code.
- m_fwd_en  in  1  M stage writes a register with ready data.
- m_fwd_addr  in  REG_AW  M stage destination register.
- m_fwd_data  in  WIDTH  M stage result.
- w_fwd_en  in  1  W stage writes a register.
- w_fwd_addr  in  REG_AW  W stage destination register.
- w_fwd_data  in  WIDTH  W stage result.
- e_valid  out  1  registered valid.
- e_alua  out  WIDTH  registered ALU A operand (forwarded rs).
- e_alub  out  WIDTH  registered ALU B operand.
- e_rtdata  out  WIDTH  registered forwarded rt value, used as store data.
- e_rs, e_rt  out  REG_AW each  registered register numbers, for downstream hazard checks.

Behaviour:
- Clock is clk, rising edge. Reset is reset_n: asynchronous, active-low.
- Forwarding (combinational, applied to the D-side inputs):
  - fa = d_rd1; if W matches rs, fa = w_fwd_data; if M matches rs, fa = m_fwd_data.
  - M has priority over W.
  - A stage "matches" only when its fwd_en = 1, its address equals the register number, and the address is not 0.
  - Register 0 never forwards; it always uses the GRF value.
  - fb is formed the same way from d_rd2 / d_rt.
- B select, by d_alusrc:
  - 0: fb.
  - 1: d_imm32.
  - 2: d_rt zero-extended to WIDTH.
  - 3: d_shamt zero-extended to WIDTH.
  - 4: constant 16, for lui-by-shift.
  - 5 to 7: all zeros.
  - When WIDTH < REG_AW or WIDTH < SHAMT_W, truncate to the low WIDTH bits.
- Pipeline register, evaluated at each rising clk edge, in priority order:
  - flush = 1: all outputs go to 0 and e_valid = 0. flush overrides stall.
  - else stall = 1: all outputs hold their current values.
  - else: e_valid <= d_valid, e_alua <= fa, e_alub <= selected B, e_rtdata <= fb, e_rs <= d_rs, e_rt <= d_rt.
- Latency: exactly 1 cycle from D-side inputs to E-side outputs. No combinational path from inputs to outputs.
- Reset: reset_n low asynchronously clears every output to 0, regardless of clk, stall or flush. The first capture occurs at the first rising edge after reset_n goes high.
- d_valid = 0 is captured like any other value. Operand contents are don't-care when the captured e_valid = 0, but still deterministic.
- Forwarding values are sampled at the capturing edge. Changes to fwd inputs during a stall do not alter held outputs.

Test Plan:
- Reset: drive reset_n = 0 mid-cycle with outputs nonzero -> all outputs are 0 immediately, before the next edge. After release, d_rd1 = 0x11, d_alusrc = 0, d_rd2 = 0x22 -> next edge gives e_alua = 0x11, e_alub = 0x22.
- Source select: d_imm32 = 0xFFFF8000, d_rt = 5'd9, d_shamt = 5'd31; step d_alusrc through 1, 2, 3, 4, 6 -> e_alub = 0xFFFF8000, 0x9, 0x1F, 0x10, 0x0 on successive cycles.
- Forward priority: d_rs = d_rt = 8; M writes 8 with 0xAAAA, W writes 8 with 0xBBBB, d_alusrc = 0 -> e_alua = e_alub = e_rtdata = 0xAAAA. With M disabled -> all three are 0xBBBB.
- Register 0: d_rs = 0, d_rd1 = 0, M and W enabled to address 0 with 0xDEAD -> e_alua = 0.
- Stall and flush: capture e_alua = 0x5; raise stall and change the inputs -> outputs hold 0x5 for 3 cycles. Assert stall and flush together -> e_valid = 0 and all outputs are 0. Release both -> new inputs are captured on the next edge.
